mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters: CPU instruction fetch and CPU data access (loads/stores).
- Sits between the cpu core and the multi-cycle memory model.
- Serialises requests with round-robin arbitration, drives a one-shot memory command and returns a one-cycle done pulse with read data.
- Blocks new fetches while the core reports halt.

Parameters:
ADDR_W, 16, address width of both requesters and the memory port
DATA_W, 16, data width
CNT_W, 16, width of the saturating fetch-stall counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
hlt  in  1  core halted; while 1, if_req is not granted
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_done  out  1  one-cycle pulse: fetch complete
if_rdata  out  DATA_W  fetched instruction, valid from if_done onward
d_req  in  1  data request, held until d_done
d_wr  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data, valid from d_done onward
mem_en  out  1  one-cycle memory command strobe
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid with mem_valid
mem_valid  in  1  memory completion (read or write), earliest one cycle after mem_en
busy  out  1  state != IDLE
stall_cnt  out  CNT_W  cycles with if_req=1 and no fetch in service; saturates

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_gnt=FETCH. All outputs 0, including mem_en, both dones, both rdatas and stall_cnt. An in-flight access is abandoned; mem_en drops immediately.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered or decoded from state only.
- IDLE, arbitration:
  - eligible_if = if_req & ~hlt; eligible_d = d_req.
  - If both are eligible, grant the one not equal to last_gnt. Otherwise grant the single eligible requester.
  - On grant: latch addr, wr (fetch forces wr=0) and wdata into mem_* regs; record gnt; set last_gnt=gnt; go to ISSUE.
  - If none are eligible, stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle; mem_wr = latched wr; go to WAIT.
- WAIT: hold mem_addr/mem_wdata stable.
  - On mem_valid: if the access was a read, capture mem_rdata into if_rdata or d_rdata per gnt; go to RESP.
  - mem_valid seen in ISSUE is ignored (protocol violation).
- RESP: assert if_done or d_done (per gnt) for this cycle only; no grant this cycle; go to IDLE.
  - Requester must drop or replace its req at the RESP edge. A req still high in the following IDLE cycle is a new request.
- Latency, measured from the first IDLE cycle with req high as cycle 0: mem_en in cycle 1, done in cycle (mem_valid cycle + 1).
  - Minimum 3 cycles (memory valid in cycle 2).
  - 4-cycle memory (valid in cycle 5): done in cycle 6.
- Writes: rdata regs are unchanged. Done still pulses.
- Request changes after grant (addr/wdata/wr edits or req drop) are ignored; the latched access completes and done pulses.
- hlt rising during an in-flight fetch: that fetch completes normally. Data requests are always served regardless of hlt.
- stall_cnt: increments each cycle if_req=1 and NOT (gnt=FETCH and state in {ISSUE, WAIT, RESP}). The increment is independent of hlt. Holds at 2^CNT_W-1.
- if_rdata and d_rdata hold their value until the next read completion for that port.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - grant IDs: GNT_FETCH=1'b0, GNT_DATA=1'b1
- One natural sub-module: sat_counter (CNT_W wide, enable, async active-low reset), instantiated for stall_cnt.
- Arbitration and FSM stay inline.

Test Plan:
- Reset: rst_n=0 mid-WAIT of a load -> same cycle mem_en=0, busy=0, d_done never pulses; after release, stall_cnt=0 and a new if_req to 0x0000 completes normally.
- Single fetch with 4-cycle memory: if_req=1, if_addr=0x0010, mem_rdata=0xB123 -> mem_en cycle 1 with mem_addr=0x0010, mem_wr=0; if_done pulse cycle 6; if_rdata=0xB123; d_done stays 0.
- Store: d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_en=1, mem_wr=1, mem_wdata=0xBEEF; d_done pulses; d_rdata unchanged from prior value 0x1234.
- Simultaneous requests after reset: if_req and d_req both high from cycle 0 -> data served first (last_gnt reset=FETCH), fetch served second; stall_cnt=7 at the fetch grant with 4-cycle memory.
- Round-robin: both requesters continuously re-request 3 times each -> grants alternate D,F,D,F,D,F with no back-to-back grant to the same port.
- Halt: hlt=1 with if_req=1, d_req=1 (load 0x0002, mem_rdata=0x00AA) -> only the load is served (d_rdata=0x00AA); no further mem_en; stall_cnt keeps incrementing; hlt=0 -> fetch granted in the next IDLE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory arbiter slice.
// Holds the FSM state codes, the grant IDs and the round-robin pick helper.
package cpu_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // When both requesters compete, the one served
  // last time loses.
  function automatic logic rr_pick(
    input logic el_if,
    input logic el_d,
    input logic last
  );
    if (el_if && el_d) return ~last;
    else if (el_d)     return GNT_DATA;
    else               return GNT_FETCH;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
// Ports: clk, rst_n (async low), en (count), cnt (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between fetch and data ports.
// Ports: if_* fetch side, d_* data side, mem_* memory side, busy, stall_cnt.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;

  logic el_if;
  logic pick;
  logic if_busy;

  assign el_if = if_req & ~hlt;
  assign pick  = rr_pick(el_if, d_req, last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if_rd_d = if_rd_q;
    d_rd_d  = d_rd_q;
    unique case (state_q)
      IDLE: begin
        if (el_if || d_req) begin
          gnt_d   = pick;
          last_d  = pick;
          state_d = ISSUE;
          if (pick == GNT_DATA) begin
            addr_d  = d_addr;
            wr_d    = d_wr;
            wdata_d = d_wdata;
          end else begin
            addr_d = if_addr;
            wr_d   = 1'b0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_valid) begin
          state_d = RESP;
          if (!wr_q) begin
            if (gnt_q == GNT_DATA) d_rd_d = mem_rdata;
            else                   if_rd_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GNT_FETCH;
      gnt_q   <= GNT_FETCH;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if_rd_q <= if_rd_d;
      d_rd_q  <= d_rd_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_wr    = wr_q & mem_en;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_done   = (state_q == RESP) & (gnt_q == GNT_FETCH);
  assign d_done    = (state_q == RESP) & (gnt_q == GNT_DATA);
  assign if_rdata  = if_rd_q;
  assign d_rdata   = d_rd_q;

  // A fetch is "in service" from ISSUE through RESP.
  assign if_busy = (gnt_q == GNT_FETCH) & busy;

  sat_counter #(
    .W(CNT_W)
  ) u_stall (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (if_req & ~if_busy),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic.
// A transaction-level model predicts grants, dones, rdata and stall_cnt.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hlt = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          busy;
  logic [CW-1:0] stall_cnt;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hlt      (hlt),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .busy     (busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];

  // Reference: one outstanding access, described by its timeline.
  bit            inflight = 0;
  bit            g_port = 0;
  bit            g_wr = 0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  int            en_cyc = -1;
  int            done_cyc = -1;
  bit            last_port = 0;
  int            ref_stall = 0;
  logic [DW-1:0] ref_if_rd = '0;
  logic [DW-1:0] ref_d_rd = '0;

  // Memory responder.
  bit            resp_act = 0;
  int            rem = 0;
  int            fixed_lat = 0;
  logic [AW-1:0] r_addr = '0;
  logic          r_wr = 1'b0;
  logic [DW-1:0] r_wdata = '0;
  int            en_count = 0;
  int            last_en_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Advance the reference by the cycle whose inputs are now applied.
  task automatic model_step();
    bit e_if;
    bit e_d;
    if (if_req && !(inflight && g_port == 1'b0) && ref_stall < SMAX)
      ref_stall++;
    if (inflight) begin
      if (done_cyc == cyc) inflight = 0;
      else if (cyc - en_cyc > 40) begin
        chk("access_age", cyc - en_cyc, 40);
        inflight = 0;
      end
    end else begin
      e_if = if_req && !hlt;
      e_d  = d_req;
      if (e_if || e_d) begin
        if (e_if && e_d) g_port = !last_port;
        else             g_port = e_d;
        last_port = g_port;
        inflight  = 1;
        en_cyc    = cyc + 1;
        done_cyc  = -1;
        if (g_port) begin
          g_addr  = d_addr;
          g_wr    = d_wr;
          g_wdata = d_wdata;
        end else begin
          g_addr  = if_addr;
          g_wr    = 0;
          g_wdata = '0;
        end
      end
    end
  endtask

  task automatic tick();
    bit dn;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    dn = inflight && (done_cyc == cyc);
    if (dn) begin
      if (g_wr) ref_mem[g_addr[7:0]] = g_wdata;
      else if (g_port) ref_d_rd = ref_mem[g_addr[7:0]];
      else ref_if_rd = ref_mem[g_addr[7:0]];
    end
    chk("busy", busy, inflight);
    chk("mem_en", mem_en, inflight && en_cyc == cyc);
    if (inflight) chk("mem_addr", mem_addr, g_addr);
    if (inflight && en_cyc == cyc) begin
      chk("mem_wr", mem_wr, g_wr);
      if (g_wr) chk("mem_wdata", mem_wdata, g_wdata);
    end
    chk("if_done", if_done, dn && !g_port);
    chk("d_done", d_done, dn && g_port);
    chk("if_rdata", if_rdata, ref_if_rd);
    chk("d_rdata", d_rdata, ref_d_rd);
    chk("stall_cnt", stall_cnt, ref_stall);
    // Drive memory inputs for the current cycle.
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    if (mem_en) begin
      en_count++;
      last_en_cyc = cyc;
      resp_act = 1;
      r_addr   = mem_addr;
      r_wr     = mem_wr;
      r_wdata  = mem_wdata;
      rem = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
      // Stray strobe during ISSUE must be ignored.
      if (fixed_lat == 0) mem_valid = ($urandom_range(0, 3) == 0);
    end else if (resp_act) begin
      rem--;
      if (rem == 0) begin
        resp_act  = 0;
        mem_valid = 1'b1;
        if (r_wr) mem[r_addr[7:0]] = r_wdata;
        else mem_rdata = mem[r_addr[7:0]];
        if (inflight) done_cyc = cyc + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hlt = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    d_wr = 1'b0;
    mem_valid = 1'b0;
    resp_act = 0;
    rem = 0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_d_done", d_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    inflight = 0;
    last_port = 0;
    ref_stall = 0;
    ref_if_rd = '0;
    ref_d_rd = '0;
    cyc = 0;
    en_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic wait_done(input bit port, output int dc);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((port ? d_done : if_done) === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", port ? d_done : if_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int dc;
    int c0;
    int e0;
    int n;
    int nd;
    int nf;
    bit pf;
    bit pd;
    bit seq [0:5];
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end

    #2;
    do_reset();

    // Single fetch, 4-cycle memory.
    fixed_lat = 4;
    mem[8'h10] = 16'hB123;
    ref_mem[8'h10] = 16'hB123;
    if_addr = 16'h0010;
    if_req = 1'b1;
    c0 = cyc;
    wait_done(0, dc);
    if_req = 1'b0;
    chk("fetch_en_cycle", last_en_cyc - c0, 1);
    chk("fetch_latency", dc - c0, 6);
    chk("fetch_rdata", if_rdata, 16'hB123);

    // Load 0x1234, then a store that must leave d_rdata alone.
    fixed_lat = 0;
    mem[8'h30] = 16'h1234;
    ref_mem[8'h30] = 16'h1234;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0030;
    wait_done(1, dc);
    chk("load_rdata", d_rdata, 16'h1234);
    d_wr = 1'b1;
    d_addr = 16'h0040;
    d_wdata = 16'hBEEF;
    wait_done(1, dc);
    d_req = 1'b0;
    d_wr = 1'b0;
    chk("store_mem_wr", r_wr, 1);
    chk("store_d_rdata", d_rdata, 16'h1234);
    chk("store_mem", mem[8'h40], 16'hBEEF);

    // Simultaneous requests right after reset.
    do_reset();
    fixed_lat = 4;
    if_addr = 16'h0010;
    d_addr = 16'h0020;
    if_req = 1'b1;
    d_req = 1'b1;
    wait_done(1, dc);
    d_req = 1'b0;
    chk("sim_d_done", dc, 6);
    tick();
    chk("sim_stall_at_fgnt", stall_cnt, 7);
    wait_done(0, dc);
    if_req = 1'b0;
    chk("sim_f_done", dc, 13);

    // Round-robin with continuous re-requests.
    do_reset();
    fixed_lat = 0;
    n = 0;
    nd = 0;
    nf = 0;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 200 && n < 6; i++) begin
      tick();
      if (d_done && n < 6) begin
        seq[n] = 1'b1;
        n++;
        nd++;
        if (nd >= 3) d_req = 1'b0;
        else d_addr = 16'($urandom_range(0, 255));
      end
      if (if_done && n < 6) begin
        seq[n] = 1'b0;
        n++;
        nf++;
        if (nf >= 3) if_req = 1'b0;
        else if_addr = 16'($urandom_range(0, 255));
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("rr_count", n, 6);
    for (int k = 0; k < 6; k++) chk("rr_order", seq[k], (k % 2 == 0));

    // Halt: only data is served, stall count saturates.
    mem[8'h02] = 16'h00AA;
    ref_mem[8'h02] = 16'h00AA;
    hlt = 1'b1;
    if_req = 1'b1;
    if_addr = 16'h0020;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0002;
    wait_done(1, dc);
    d_req = 1'b0;
    chk("halt_load", d_rdata, 16'h00AA);
    e0 = en_count;
    repeat (20) tick();
    chk("halt_no_en", en_count - e0, 0);
    chk("halt_stall_sat", stall_cnt, SMAX);
    hlt = 1'b0;
    c0 = cyc;
    tick();
    chk("unhalt_grant", last_en_cyc - c0, 1);
    wait_done(0, dc);
    if_req = 1'b0;

    // Reset in the middle of a load.
    fixed_lat = 4;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0005;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    do_reset();
    repeat (8) tick();
    if_addr = 16'h0000;
    if_req = 1'b1;
    c0 = cyc;
    wait_done(0, dc);
    if_req = 1'b0;
    chk("post_rst_latency", dc - c0, 6);
    chk("post_rst_rdata", if_rdata, ref_mem[0]);

    // Random traffic.
    fixed_lat = 0;
    pf = 0;
    pd = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (if_done) begin
        pf = 0;
        if_req = 1'b0;
      end
      if (d_done) begin
        pd = 0;
        d_req = 1'b0;
      end
      if (!pf && $urandom_range(0, 2) == 0) begin
        pf = 1;
        if_req = 1'b1;
        if_addr = 16'($urandom_range(0, 255));
      end
      if (!pd && $urandom_range(0, 2) == 0) begin
        pd = 1;
        d_req = 1'b1;
        d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
      end else if (pd && $urandom_range(0, 7) == 0) begin
        d_addr = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
      end
      if (pf && $urandom_range(0, 7) == 0)
        if_addr = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) hlt = ~hlt;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    hlt = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
